// File: rtl/alu_sequencer.sv
// alu_sequencer: instruction fetch/execute controller for a 16-bit ALU.
// Fetches 16-bit instructions over a req/ack port, holds R0/R1, resolves
// branches from a latched {Z,N,C,O} flag register and keeps a return stack
// for JMP/RET.
// Optional macro ALU_SEQ_PERF_EN adds a saturating 32-bit EXEC-cycle counter
// on output instr_count.
module alu_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_ack,
   output logic [5:0]        alu_opcode,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   input  logic [15:0]       alu_result,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              alu_c,
   input  logic              alu_o,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output logic [15:0]       r0_out,
   output logic [15:0]       r1_out,
   output logic [3:0]        flags_out
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [31:0]       instr_count
`endif
);

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [5:0] OP_CMP      = 6'h0B;
   localparam logic [5:0] OP_TST      = 6'h0C;
   localparam logic [5:0] OP_LAST_ALU = 6'h11;
   localparam logic [5:0] OP_BRZ      = 6'h12;
   localparam logic [5:0] OP_BRN      = 6'h13;
   localparam logic [5:0] OP_BRC      = 6'h14;
   localparam logic [5:0] OP_BRO      = 6'h15;
   localparam logic [5:0] OP_BRA      = 6'h16;
   localparam logic [5:0] OP_JMP      = 6'h17;
   localparam logic [5:0] OP_RET      = 6'h18;
   localparam logic [5:0] OP_HALT     = 6'h3F;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [15:0]       ir_q;
   logic [15:0]       r0_q;
   logic [15:0]       r1_q;
   logic [3:0]        flags_q;
   logic [SP_W-1:0]   sp_q;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
   logic              imem_req_q;
   logic              busy_q;
   logic              halted_q;
   logic              err_q;

   logic [5:0]        op_d;
   logic              dst_d;
   logic              imm_d;
   logic [7:0]        imm8_d;
   logic [15:0]       opnd_a_d;
   logic [15:0]       opnd_b_d;
   logic [ADDR_W-1:0] target_d;
   logic [ADDR_W-1:0] pc_inc_d;
   logic [IDX_W-1:0]  push_idx_d;
   logic [IDX_W-1:0]  pop_idx_d;
   logic              stack_full_d;
   logic              stack_empty_d;
   logic              branch_taken_d;

   // Decode the instruction register: fields, operands, targets, branch test.
   always_comb begin
      op_d          = ir_q[15:10];
      dst_d         = ir_q[9];
      imm_d         = ir_q[8];
      imm8_d        = ir_q[7:0];
      opnd_a_d      = dst_d ? r1_q : r0_q;
      if (imm_d) begin
         opnd_b_d = {8'h00, imm8_d};
      end else if (dst_d) begin
         opnd_b_d = r0_q;
      end else begin
         opnd_b_d = r1_q;
      end
      target_d      = ADDR_W'(imm8_d);
      pc_inc_d      = pc_q + ADDR_W'(1);
      push_idx_d    = IDX_W'(sp_q);
      pop_idx_d     = IDX_W'(sp_q - SP_W'(1));
      stack_full_d  = (sp_q == SP_W'(STACK_DEPTH));
      stack_empty_d = (sp_q == {SP_W{1'b0}});
      case (op_d)
         OP_BRZ:  branch_taken_d = flags_q[3];
         OP_BRN:  branch_taken_d = flags_q[2];
         OP_BRC:  branch_taken_d = flags_q[1];
         OP_BRO:  branch_taken_d = flags_q[0];
         default: branch_taken_d = 1'b0;
      endcase
   end

   // ALU drive: operands only during EXEC, zero otherwise.
   always_comb begin
      if (state_q == S_EXEC) begin
         alu_opcode = op_d;
         alu_a      = opnd_a_d;
         alu_b      = opnd_b_d;
      end else begin
         alu_opcode = 6'h00;
         alu_a      = 16'h0000;
         alu_b      = 16'h0000;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign err       = err_q;
   assign r0_out    = r0_q;
   assign r1_out    = r1_q;
   assign flags_out = flags_q;

   // Sequencer FSM with registered status outputs, registers, PC and stack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= {ADDR_W{1'b0}};
         ir_q       <= 16'h0000;
         r0_q       <= 16'h0000;
         r1_q       <= 16'h0000;
         flags_q    <= 4'h0;
         sp_q       <= {SP_W{1'b0}};
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= {ADDR_W{1'b0}};
         end
         imem_req_q <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state_q    <= S_FETCH;
                  pc_q       <= {ADDR_W{1'b0}};
                  sp_q       <= {SP_W{1'b0}};
                  err_q      <= 1'b0;
                  imem_req_q <= 1'b1;
                  busy_q     <= 1'b1;
                  halted_q   <= 1'b0;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  ir_q       <= imem_rdata;
                  state_q    <= S_EXEC;
                  imem_req_q <= 1'b0;
               end
            end
            S_EXEC: begin
               // Default: fall through to the next sequential fetch.
               state_q    <= S_FETCH;
               imem_req_q <= 1'b1;
               pc_q       <= pc_inc_d;
               if (op_d <= OP_LAST_ALU) begin
                  flags_q <= {alu_z, alu_n, alu_c, alu_o};
                  if ((op_d != OP_CMP) && (op_d != OP_TST)) begin
                     if (dst_d) begin
                        r1_q <= alu_result;
                     end else begin
                        r0_q <= alu_result;
                     end
                  end
               end else begin
                  case (op_d)
                     OP_BRZ, OP_BRN, OP_BRC, OP_BRO: begin
                        if (branch_taken_d) begin
                           pc_q <= target_d;
                        end
                     end
                     OP_BRA: begin
                        pc_q <= target_d;
                     end
                     OP_JMP: begin
                        if (stack_full_d) begin
                           pc_q       <= pc_q;
                           err_q      <= 1'b1;
                           state_q    <= S_HALT;
                           imem_req_q <= 1'b0;
                           busy_q     <= 1'b0;
                           halted_q   <= 1'b1;
                        end else begin
                           stack_q[push_idx_d] <= pc_inc_d;
                           sp_q                <= sp_q + SP_W'(1);
                           pc_q                <= target_d;
                        end
                     end
                     OP_RET: begin
                        if (stack_empty_d) begin
                           pc_q       <= pc_q;
                           err_q      <= 1'b1;
                           state_q    <= S_HALT;
                           imem_req_q <= 1'b0;
                           busy_q     <= 1'b0;
                           halted_q   <= 1'b1;
                        end else begin
                           pc_q <= stack_q[pop_idx_d];
                           sp_q <= sp_q - SP_W'(1);
                        end
                     end
                     OP_HALT: begin
                        pc_q       <= pc_q;
                        state_q    <= S_HALT;
                        imem_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        halted_q   <= 1'b1;
                     end
                     default: begin
                        pc_q       <= pc_q;
                        err_q      <= 1'b1;
                        state_q    <= S_HALT;
                        imem_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        halted_q   <= 1'b1;
                     end
                  endcase
               end
            end
            default: begin
               state_q    <= S_IDLE;
               imem_req_q <= 1'b0;
               busy_q     <= 1'b0;
               halted_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_PERF_EN
   logic [31:0] instr_count_q;

   // Saturating count of EXEC cycles, cleared by reset or an accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count_q <= 32'h0000_0000;
      end else if (((state_q == S_IDLE) || (state_q == S_HALT)) && start) begin
         instr_count_q <= 32'h0000_0000;
      end else if ((state_q == S_EXEC) && (instr_count_q != 32'hFFFF_FFFF)) begin
         instr_count_q <= instr_count_q + 32'd1;
      end
   end

   assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: models instruction memory and the ALU,
// queues expected fetch addresses and checks registers/flags/status.
module tb_alu_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ack;
   logic [5:0]  alu_opcode;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        alu_z, alu_n, alu_c, alu_o;
   logic        busy, halted, err;
   logic [15:0] r0_out, r1_out;
   logic [3:0]  flags_out;
`ifdef ALU_SEQ_PERF_EN
   logic [31:0] instr_count;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] prog [256];
   logic [7:0]  sb_q [$];

   alu_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_z      (alu_z),
      .alu_n      (alu_n),
      .alu_c      (alu_c),
      .alu_o      (alu_o),
      .busy       (busy),
      .halted     (halted),
      .err        (err),
      .r0_out     (r0_out),
      .r1_out     (r1_out),
      .flags_out  (flags_out)
`ifdef ALU_SEQ_PERF_EN
      ,
      .instr_count(instr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: 0x00 ADD, 0x0B CMP, 0x0C TST, 0x0D MOV, 0x0E LSL.
   always_comb begin
      logic [16:0] t;
      t          = 17'd0;
      alu_result = 16'h0000;
      alu_c      = 1'b0;
      alu_o      = 1'b0;
      case (alu_opcode)
         6'h00: begin
            t = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = t[15:0];
            alu_c = t[16];
            alu_o = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
         end
         6'h0B: begin
            t = {1'b0, alu_a} - {1'b0, alu_b};
            alu_result = t[15:0];
            alu_c = t[16];
            alu_o = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
         end
         6'h0C: alu_result = alu_a & alu_b;
         6'h0D: alu_result = alu_b;
         6'h0E: begin
            t = {1'b0, alu_a} << alu_b[3:0];
            alu_result = t[15:0];
            alu_c = t[16];
         end
         default: alu_result = 16'h0000;
      endcase
      alu_z = (alu_result == 16'h0000);
      alu_n = alu_result[15];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 16'hFC00;
   endtask

   // Pulse start, serve fetches with ack_delay wait cycles, compare each fetch
   // address against the queue, stop on halted. lat counts rising edges from
   // the one sampling start to the one raising halted.
   task automatic run_prog(input int ack_delay, output int lat, output int first_req_cycles);
      int cycles;
      int wait_cnt;
      bit fresh;
      bit first;
      logic [7:0] exp_addr;
      cycles = 0; wait_cnt = 0; fresh = 1'b1; first = 1'b1;
      first_req_cycles = 0; exp_addr = 8'h00;
      @(negedge clk);
      start = 1'b1;
      forever begin
         @(negedge clk);
         start = 1'b0;
         imem_ack = 1'b0;
         cycles++;
         if (halted === 1'b1 || cycles > 2000) break;
         if (imem_req === 1'b1) begin
            if (fresh) begin
               if (sb_q.size() == 0) chk("sb_extra_fetch", 32'(imem_addr), 32'hFFFF_FFFF);
               else exp_addr = sb_q.pop_front();
               fresh = 1'b0;
            end
            chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
            if (first) first_req_cycles++;
            if (wait_cnt == ack_delay) begin
               imem_ack = 1'b1;
               imem_rdata = prog[imem_addr];
               wait_cnt = 0; fresh = 1'b1; first = 1'b0;
            end else begin
               wait_cnt++;
            end
         end
      end
      if (cycles > 2000) chk("halt_timeout", 32'(halted), 32'd1);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      lat = cycles - 1;
   endtask

   initial begin
      int lat;
      int rq;
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_r0", 32'(r0_out), 32'd0);
      chk("rst_r1", 32'(r1_out), 32'd0);
      chk("rst_flags", 32'(flags_out), 32'd0);
      chk("rst_opcode", 32'(alu_opcode), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // ADD R0,#5; ADD R0,#3; HALT
      clear_prog();
      prog[0] = 16'h0105; prog[1] = 16'h0103; prog[2] = 16'hFC00;
      sb_q = {8'h00, 8'h01, 8'h02};
      run_prog(0, lat, rq);
      chk("a_latency", 32'(lat), 32'd6);
      chk("a_r0", 32'(r0_out), 32'h8);
      chk("a_flags", 32'(flags_out), 32'h0);
      chk("a_halted", 32'(halted), 32'd1);
      chk("a_err", 32'(err), 32'd0);
      chk("a_busy", 32'(busy), 32'd0);
      chk("a_opcode_gated", 32'(alu_opcode), 32'd0);
`ifdef ALU_SEQ_PERF_EN
      chk("a_instr_count", instr_count, 32'd3);
`endif

      // MOV R1,#3; MOV R0,#0x7F; LSL R0,#8; ADD R0,#0xFF; ADD R0,#1; HALT
      clear_prog();
      prog[0] = 16'h3703; prog[1] = 16'h357F; prog[2] = 16'h3908;
      prog[3] = 16'h01FF; prog[4] = 16'h0101; prog[5] = 16'hFC00;
      sb_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run_prog(0, lat, rq);
      chk("ovf_r0", 32'(r0_out), 32'h8000);
      chk("ovf_r1", 32'(r1_out), 32'h3);
      chk("ovf_flags", 32'(flags_out), 32'b0101);

      // MOV R0,#8; CMP R0,#8; BRN 0x30 (not taken); BRZ 0x10; ADD R1,R0; HALT
      clear_prog();
      prog[0] = 16'h3508; prog[1] = 16'h2D08; prog[2] = 16'h4C30;
      prog[3] = 16'h4810; prog[16] = 16'h0200; prog[17] = 16'hFC00;
      sb_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11};
      run_prog(0, lat, rq);
      chk("br_r0", 32'(r0_out), 32'h8);
      chk("br_r1", 32'(r1_out), 32'h000B);
      chk("br_flags", 32'(flags_out), 32'h0);

      // Leave Z=1,C=1 latched: MOV R0,#0x80; LSL R0,#8; LSL R0,#1; HALT
      clear_prog();
      prog[0] = 16'h3580; prog[1] = 16'h3908; prog[2] = 16'h3901;
      sb_q = {8'h00, 8'h01, 8'h02, 8'h03};
      run_prog(0, lat, rq);
      chk("carry_flags", 32'(flags_out), 32'b1010);
      chk("carry_r0", 32'(r0_out), 32'h0);

      // BRC 0xFF taken on retained C; MOV at 0xFF; PC wraps to 0; BRC not taken
      clear_prog();
      prog[0] = 16'h50FF; prog[255] = 16'h3501; prog[1] = 16'hFC00;
      sb_q = {8'h00, 8'hFF, 8'h00, 8'h01};
      run_prog(0, lat, rq);
      chk("wrap_r0", 32'(r0_out), 32'h1);
      chk("wrap_flags", 32'(flags_out), 32'h0);

      // JMP 0x20 at PC=3, RET at 0x20, HALT at 4
      clear_prog();
      prog[0] = 16'h3501; prog[1] = 16'h3501; prog[2] = 16'h3501;
      prog[3] = 16'h5C20; prog[32] = 16'h6000; prog[4] = 16'hFC00;
      sb_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h04};
      run_prog(0, lat, rq);
      chk("jmp_err", 32'(err), 32'd0);
      chk("jmp_halted", 32'(halted), 32'd1);

      // Five nested JMPs with a 4-deep stack: the fifth overflows
      clear_prog();
      prog[0] = 16'h5C01; prog[1] = 16'h5C02; prog[2] = 16'h5C03;
      prog[3] = 16'h5C04; prog[4] = 16'h5C05;
      sb_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      run_prog(0, lat, rq);
      chk("nest_err", 32'(err), 32'd1);
      chk("nest_halted", 32'(halted), 32'd1);
      chk("nest_pc_kept", 32'(imem_addr), 32'h4);

      // RET with an empty stack
      clear_prog();
      prog[0] = 16'h6000;
      sb_q = {8'h00};
      run_prog(0, lat, rq);
      chk("ret_empty_err", 32'(err), 32'd1);
      chk("ret_empty_halted", 32'(halted), 32'd1);

      // Ack delayed 3 cycles: request held for 4 cycles with stable address
      clear_prog();
      prog[0] = 16'h3502;
      sb_q = {8'h00, 8'h01};
      run_prog(3, lat, rq);
      chk("slow_req_cycles", 32'(rq), 32'd4);
      chk("slow_r0", 32'(r0_out), 32'h2);
      chk("slow_err", 32'(err), 32'd0);

      // Reset while waiting for ack; a pending ack afterwards is ignored
      clear_prog();
      prog[0] = 16'h3501;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("wait_req1", 32'(imem_req), 32'd1);
      @(negedge clk);
      chk("wait_req2", 32'(imem_req), 32'd1);
      rst = 1'b1; imem_ack = 1'b1;
      #1;
      chk("rst_req_drop", 32'(imem_req), 32'd0);
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_r0", 32'(r0_out), 32'd0);
      chk("mid_rst_flags", 32'(flags_out), 32'd0);
      chk("mid_rst_addr", 32'(imem_addr), 32'd0);
      chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_req", 32'(imem_req), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_halted", 32'(halted), 32'd0);
      imem_ack = 1'b0;

      // Illegal opcode 0x20, then start clears err and fetch resumes at 0
      clear_prog();
      prog[0] = 16'h8000;
      sb_q = {8'h00};
      run_prog(0, lat, rq);
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_halted", 32'(halted), 32'd1);
      prog[0] = 16'hFC00;
      sb_q = {8'h00};
      run_prog(0, lat, rq);
      chk("restart_err", 32'(err), 32'd0);
      chk("restart_halted", 32'(halted), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
